// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// Optional macro DIV_EARLY_TERM_EN: finish in one edge when the dividend is already smaller than the divisor.
module seq_restoring_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow,
    output logic [1:0]     dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and results hold until taken.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    state_t        state_q, state_d;
    logic [N:0]    r9_q, r9_d;
    logic [N-1:0]  qs_q, qs_d;
    logic [N-1:0]  b_q, b_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [N:0]    trial;
    logic [N:0]    trial_diff;
    logic          qbit;
    logic [N:0]    r9_next;
    logic [N-1:0]  qs_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial      = {r9_q[N-1:0], qs_q[N-1]};
        trial_diff = trial - {1'b0, b_q};
        qbit       = (trial >= {1'b0, b_q});
        r9_next    = qbit ? trial_diff : trial;
        qs_next    = {qs_q[N-2:0], qbit};
    end

    always_comb begin
        state_d = state_q;
        r9_d    = r9_q;
        qs_d    = qs_q;
        b_d     = b_q;
        count_d = count_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (dividend[2*N-1:N] >= divisor) begin
                        quot_d  = '1;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end
`ifdef DIV_EARLY_TERM_EN
                    else if ((dividend[2*N-1:N] == '0) && (dividend[N-1:0] < divisor)) begin
                        quot_d  = '0;
                        rem_d   = dividend[N-1:0];
                        state_d = S_DONE;
                    end
`endif
                    else begin
                        r9_d    = {1'b0, dividend[2*N-1:N]};
                        qs_d    = dividend[N-1:0];
                        b_d     = divisor;
                        count_d = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                r9_d    = r9_next;
                qs_d    = qs_next;
                count_d = count_q + 1'b1;
                // r9 stays below the divisor, so its low N bits are the whole remainder.
                if (count_q == LAST_ITER) begin
                    quot_d  = qs_next;
                    rem_d   = r9_next[N-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r9_q    <= '0;
            qs_q    <= '0;
            b_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r9_q    <= r9_d;
            qs_q    <= qs_d;
            b_q     <= b_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases plus random operands vs. an arithmetic model.
module tb_seq_restoring_divider;

  localparam int N = 8;
  localparam int RW = 2 * N + 2;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;
  logic [1:0]     dbg_state;

  int checks;
  int errors;
  logic [RW-1:0] exp_q[$];

  seq_restoring_divider #(.N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference: {div_by_zero, overflow, quotient, remainder} and latency in edges after accept
  task automatic model(input logic [2*N-1:0] p, input logic [N-1:0] b,
                       output logic [RW-1:0] res, output int lat);
    int pi, bi;
    pi = int'(p);
    bi = int'(b);
    if (bi == 0) begin
      res = {1'b1, 1'b0, {N{1'b1}}, {N{1'b0}}};
      lat = 0;
    end else if (pi / bi >= (1 << N)) begin
      res = {1'b0, 1'b1, {N{1'b1}}, {N{1'b0}}};
      lat = 0;
    end else begin
      res = {2'b00, N'(pi / bi), N'(pi % bi)};
`ifdef DIV_EARLY_TERM_EN
      lat = (pi < bi) ? 0 : N;
`else
      lat = N;
`endif
    end
  endtask

  // driver: issue one division, watch latency, hold out_ready low for 'hold' cycles, then take it
  task automatic run_div(input logic [2*N-1:0] p, input logic [N-1:0] b, input int hold,
                         input bit noise);
    logic [RW-1:0] res;
    logic [RW-1:0] exp_res;
    int exp_lat;
    int lat;
    int w;
    model(p, b, res, exp_lat);
    exp_q.push_back(res);
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = p;
    divisor  = b;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < N + 6) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("out_valid", 32'(out_valid), 32'd1);
    exp_res = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check_eq("held_result", {14'd0, div_by_zero, overflow, quotient, remainder}, 32'(exp_res));
      check_eq("in_ready_in_done", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    check_eq("result", {14'd0, div_by_zero, overflow, quotient, remainder}, 32'(exp_res));
    check_eq("out_valid_at_take", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("in_ready_after_take", 32'(in_ready), 32'd1);
    check_eq("out_valid_after_take", 32'(out_valid), 32'd0);
    check_eq("flags_after_take", {30'd0, div_by_zero, overflow}, 32'd0);
  endtask

  initial begin
    logic [2*N-1:0] p;
    logic [N-1:0] b;
    int sel;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_outputs", {14'd0, div_by_zero, overflow, quotient, remainder}, 32'd0);
    rst_n = 1'b1;

    // directed cases
    run_div(16'd35000, 8'd200, 0, 1'b0);
    run_div(16'd65025, 8'd255, 0, 1'b0);
    run_div(16'd65535, 8'd255, 0, 1'b0);
    run_div(16'd1234, 8'd0, 0, 1'b1);
    run_div(16'd5000, 8'd9, 0, 1'b1);
    run_div(16'd1000, 8'd7, 5, 1'b0);
    run_div(16'd100, 8'd200, 0, 1'b0);

    // reset in the middle of a division
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'd50000;
    divisor  = 8'd250;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrun_reset_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrun_reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrun_reset_outputs", {14'd0, div_by_zero, overflow, quotient, remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < N + 4; k++) begin
      @(negedge clk);
      check_eq("no_output_after_abort", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    run_div(16'd300, 8'd3, 0, 1'b0);

    // random operands, biased to cover normal, overflow, zero-divisor and small-dividend cases
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      p = 16'($urandom);
      if (sel == 0) b = '0;
      else if (b == '0) b = 8'd1;
      if (sel >= 2 && sel <= 7 && b != '0) p = {8'($urandom_range(0, int'(b) - 1)), 8'($urandom)};
      if (sel == 8 && b != '0) p = 16'($urandom_range(0, int'(b) - 1));
      run_div(p, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
